// File: rtl/imem_mrmw.sv
// Multi-read, multi-write on-chip memory with a 2-cycle read pipeline and a post-reset zero-fill sweep.
// Optional macro IMEM_BYPASS_EN forwards same-cycle write data to reads of the same address.
module imem_mrmw #(
    parameter int ADDRBIT = 11,
    parameter int DEPTH   = 2048,
    parameter int WIDTH   = 8,
    parameter int NRD     = 2,
    parameter int NWR     = 2
) (
    input  logic                     clk1x,
    input  logic                     rst1x,
    input  logic [NWR-1:0]           we,
    input  logic [NWR*ADDRBIT-1:0]   wa,
    input  logic [NWR*WIDTH-1:0]     di,
    input  logic [NRD-1:0]           re,
    input  logic [NRD*ADDRBIT-1:0]   ra,
    output logic [NRD*WIDTH-1:0]     dout,
    output logic [NRD-1:0]           dvld,
    output logic                     busy,
    output logic                     wcoll
);

    localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [ADDRBIT:0]   DEPTH_W = (ADDRBIT+1)'(DEPTH);
    localparam logic [ADDRBIT-1:0] LAST_ADDR = ADDRBIT'(DEPTH - 1);

    typedef enum logic {
        CLEAR = 1'b0,
        READY = 1'b1
    } state_t;

    state_t             state_r;
    state_t             state_s;
    logic [ADDRBIT-1:0] clr_ptr_r;

    logic [WIDTH-1:0]   mem_r [0:DEPTH-1];

    logic [ADDRBIT-1:0] wa_s [NWR];
    logic [WIDTH-1:0]   di_s [NWR];
    logic [ADDRBIT-1:0] ra_s [NRD];
    logic [NWR-1:0]     wr_en_s;
    logic [WIDTH-1:0]   rd_s [NRD];

    logic [NRD-1:0]     vld1_r;
    logic [WIDTH-1:0]   rd1_r [NRD];

    function automatic logic in_range(input logic [ADDRBIT-1:0] a);
        return ({1'b0, a} < DEPTH_W);
    endfunction

    assign busy = (state_r == CLEAR);

    // Unpack the flat port buses and qualify writes (dropped while clearing or out of range).
    always_comb begin
        for (int k = 0; k < NWR; k++) begin
            wa_s[k]    = wa[k*ADDRBIT +: ADDRBIT];
            di_s[k]    = di[k*WIDTH +: WIDTH];
            wr_en_s[k] = we[k] & ~busy & in_range(wa_s[k]);
        end
        for (int j = 0; j < NRD; j++) begin
            ra_s[j] = ra[j*ADDRBIT +: ADDRBIT];
        end
    end

    // Clear FSM next-state: leave CLEAR once the last word has been zeroed.
    always_comb begin
        state_s = state_r;
        case (state_r)
            CLEAR: begin
                if (clr_ptr_r == LAST_ADDR) begin
                    state_s = READY;
                end else begin
                    state_s = CLEAR;
                end
            end
            READY:   state_s = READY;
            default: state_s = CLEAR;
        endcase
    end

    // Clear FSM state and sweep pointer.
    always_ff @(posedge clk1x) begin
        if (rst1x) begin
            state_r   <= CLEAR;
            clr_ptr_r <= '0;
        end else begin
            state_r <= state_s;
            if (busy && (clr_ptr_r != LAST_ADDR)) begin
                clr_ptr_r <= clr_ptr_r + {{(ADDRBIT-1){1'b0}}, 1'b1};
            end else begin
                clr_ptr_r <= '0;
            end
        end
    end

    // Memory array: zero-fill during the sweep, otherwise user writes with port 0 applied last so it wins.
    always_ff @(posedge clk1x) begin
        if (!rst1x) begin
            if (busy) begin
                mem_r[clr_ptr_r[IW-1:0]] <= '0;
            end else begin
                for (int k = NWR - 1; k >= 0; k--) begin
                    if (wr_en_s[k]) begin
                        mem_r[wa_s[k][IW-1:0]] <= di_s[k];
                    end
                end
            end
        end
    end

    // Read lookup; the array is sampled before this edge's writes land, so plain reads see old data.
    always_comb begin
        for (int j = 0; j < NRD; j++) begin
            rd_s[j] = '0;
            if (in_range(ra_s[j])) begin
                rd_s[j] = mem_r[ra_s[j][IW-1:0]];
            end else begin
                rd_s[j] = '0;
            end
`ifdef IMEM_BYPASS_EN
            for (int k = NWR - 1; k >= 0; k--) begin
                if (wr_en_s[k] && (wa_s[k] == ra_s[j])) begin
                    rd_s[j] = di_s[k];
                end
            end
`endif
        end
    end

    // Read pipeline stage 1: capture lookup result and request valid.
    always_ff @(posedge clk1x) begin
        if (rst1x) begin
            vld1_r <= '0;
            for (int j = 0; j < NRD; j++) begin
                rd1_r[j] <= '0;
            end
        end else begin
            vld1_r <= re & {NRD{~busy}};
            for (int j = 0; j < NRD; j++) begin
                rd1_r[j] <= rd_s[j];
            end
        end
    end

    // Read pipeline stage 2: present data, holding each slice until its next valid result.
    always_ff @(posedge clk1x) begin
        if (rst1x) begin
            dvld <= '0;
            dout <= '0;
        end else begin
            dvld <= vld1_r;
            for (int j = 0; j < NRD; j++) begin
                if (vld1_r[j]) begin
                    dout[j*WIDTH +: WIDTH] <= rd1_r[j];
                end
            end
        end
    end

    generate
        if (NWR > 1) begin : g_coll
            // Collision flag reflects the current cycle's write request.
            always_comb begin
                wcoll = ~rst1x & ~busy & we[0] & we[1] & (wa_s[0] == wa_s[1]);
            end
        end else begin : g_nocoll
            assign wcoll = 1'b0;
        end
    endgenerate

endmodule

// File: tb/tb_imem_mrmw.sv
// Randomized self-checking bench for imem_mrmw against a behavioural memory model.
module tb_imem_mrmw;

    localparam int AB = 5;
    localparam int D  = 16;
    localparam int W  = 8;
    localparam int NR = 2;
    localparam int NW = 2;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic [NW-1:0]     we;
    logic [NW*AB-1:0]  wa;
    logic [NW*W-1:0]   di;
    logic [NR-1:0]     re;
    logic [NR*AB-1:0]  ra;
    logic [NR*W-1:0]   dout;
    logic [NR-1:0]     dvld;
    logic              busy;
    logic              wcoll;

    always #5 clk = ~clk;

    imem_mrmw #(.ADDRBIT(AB), .DEPTH(D), .WIDTH(W), .NRD(NR), .NWR(NW)) dut (
        .clk1x(clk), .rst1x(rst), .we(we), .wa(wa), .di(di),
        .re(re), .ra(ra), .dout(dout), .dvld(dvld), .busy(busy), .wcoll(wcoll)
    );

    int total = 0;
    int bad   = 0;

    logic [W-1:0] mem_m [D];
    int           clr_left = 0;
    logic [NR-1:0] s1_v = '0;
    logic [NR-1:0] exp_vld = '0;
    logic [W-1:0] s1_d [NR];
    logic [W-1:0] exp_do [NR];
    bit           chk_en = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [W-1:0] model_read(input int a);
        logic [W-1:0] v;
        v = (a < D) ? mem_m[a] : '0;
`ifdef IMEM_BYPASS_EN
        for (int k = NW - 1; k >= 0; k--) begin
            if (we[k] && (int'(wa[k*AB +: AB]) == a) && (a < D)) v = di[k*W +: W];
        end
`endif
        return v;
    endfunction

    // Abstract model of one clock edge: memory is a plain array, the read path a two-step delay.
    task automatic model_edge();
        bit bsy;
        if (rst) begin
            for (int i = 0; i < D; i++) mem_m[i] = '0;
            clr_left = D;
            s1_v = '0;
            exp_vld = '0;
            for (int j = 0; j < NR; j++) exp_do[j] = '0;
        end else begin
            bsy = (clr_left > 0);
            exp_vld = s1_v;
            for (int j = 0; j < NR; j++) if (s1_v[j]) exp_do[j] = s1_d[j];
            for (int j = 0; j < NR; j++) begin
                s1_v[j] = !bsy && re[j];
                s1_d[j] = model_read(int'(ra[j*AB +: AB]));
            end
            if (!bsy) begin
                for (int k = NW - 1; k >= 0; k--) begin
                    if (we[k] && (int'(wa[k*AB +: AB]) < D)) mem_m[int'(wa[k*AB +: AB])] = di[k*W +: W];
                end
            end
            if (clr_left > 0) clr_left--;
        end
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        chk_en = 1'b1;
        #1;
    endtask

    task automatic set_idle();
        we = '0; wa = '0; di = '0; re = '0; ra = '0;
    endtask

    task automatic wr(input int port, input int addr, input int data);
        we[port] = 1'b1;
        wa[port*AB +: AB] = AB'(addr);
        di[port*W +: W] = W'(data);
    endtask

    task automatic rd(input int port, input int addr);
        re[port] = 1'b1;
        ra[port*AB +: AB] = AB'(addr);
    endtask

    // Per-cycle comparison of every DUT output against the model.
    always @(negedge clk) begin
        if (chk_en) begin
            check("busy", 32'(busy), 32'(clr_left > 0));
            check("dvld", 32'(dvld), 32'(exp_vld));
            for (int j = 0; j < NR; j++) check($sformatf("do%0d", j), 32'(dout[j*W +: W]), 32'(exp_do[j]));
            check("wcoll", 32'(wcoll),
                  32'(!rst && (clr_left == 0) && (we == 2'b11) && (wa[AB-1:0] == wa[2*AB-1:AB])));
        end
    end

    // Clear window: busy for exactly D cycles while stray requests are ignored.
    task automatic busy_window(input string tag);
        for (int i = 0; i <= D; i++) begin
            set_idle();
            check(tag, 32'(busy), 32'(i < D));
            if (i < D) check({tag, "_dvld"}, 32'(dvld), 32'd0);
            if (i == 2) begin wr(0, 3, 8'hFF); rd(0, 3); rd(1, 3); end
            if (i == 5) wr(1, 9, 8'h77);
            if (i == 8) begin wr(0, 4, 8'h01); wr(1, 4, 8'h02); end
            step();
        end
        set_idle();
    endtask

    initial begin
        set_idle();
        rst = 1'b1;
        step();
        step();
        check("rst_busy", 32'(busy), 32'd1);
        check("rst_do", 32'(dout), 32'd0);
        rst = 1'b0;
        busy_window("busy_win");

        for (int a = 0; a < D; a++) begin
            set_idle(); rd(0, a); rd(1, D - 1 - a); step();
        end
        set_idle(); step(); step();
        check("sweep_do", 32'(dout), 32'd0);

        wr(0, 20, 8'hAB); step();
        set_idle(); rd(0, 20); step();
        set_idle(); step();
        check("oor_dvld", 32'(dvld[0]), 32'd1);
        check("oor_do", 32'(dout[7:0]), 32'd0);

        wr(0, 3, 8'h5A); step();
        set_idle(); rd(0, 3); rd(1, 3); step();
        set_idle(); step();
        check("raw_dvld", 32'(dvld), 32'd3);
        check("raw_do", 32'(dout), 32'h5A5A);

        wr(0, 7, 8'h11); wr(1, 7, 8'h22);
        #2 check("coll_hi", 32'(wcoll), 32'd1);
        step();
        set_idle();
        #1 check("coll_lo", 32'(wcoll), 32'd0);
        rd(1, 7); step();
        set_idle(); step();
        check("coll_win", 32'(dout[15:8]), 32'h11);

        wr(0, 7, 8'h33); rd(0, 7); step();
        set_idle(); step();
`ifdef IMEM_BYPASS_EN
        check("same_cyc", 32'(dout[7:0]), 32'h33);
`else
        check("same_cyc", 32'(dout[7:0]), 32'h11);
`endif
        rd(0, 7); step();
        set_idle(); step();
        check("after_wr", 32'(dout[7:0]), 32'h33);

        for (int i = 0; i < 3; i++) begin
            set_idle(); rd(0, i); rd(1, 7); step();
        end
        set_idle();
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("flush_dvld", 32'(dvld), 32'd0);
        busy_window("rst_win");

        for (int c = 0; c < 800; c++) begin
            we = NW'($urandom);
            for (int k = 0; k < NW; k++) begin
                wa[k*AB +: AB] = AB'($urandom_range(0, D + 3));
                di[k*W +: W]   = W'($urandom);
            end
            if ($urandom_range(0, 3) == 0) wa[2*AB-1:AB] = wa[AB-1:0];
            re = NR'($urandom);
            for (int j = 0; j < NR; j++) ra[j*AB +: AB] = AB'($urandom_range(0, D + 3));
            rst = ($urandom_range(0, 249) == 0);
            step();
        end
        rst = 1'b0;
        set_idle();
        for (int c = 0; c < D + 4; c++) step();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
